// File: rtl/motoro3_pkg.sv
// motoro3_pkg
// Shared definitions for the motoro3 step sequencer slice: FSM state
// encoding, the idle/maximum commutation step codes, the minimum step and
// alignment lengths, and a small clamp helper used when latching lengths.
package motoro3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ALIGN    = 2'd1,
        ST_RUN      = 2'd2,
        ST_STOPPING = 2'd3
    } seqState_t;

    localparam logic [3:0]  SG_STEP_IDLE  = 4'd15;
    localparam logic [3:0]  SG_STEP_MAX   = 4'd11;
    localparam logic [24:0] STEP_LEN_MIN  = 25'd4;
    localparam logic [24:0] ALIGN_LEN_MIN = 25'd1;

    // Raise a requested length to a floor so the First/Last decodes never collide.
    function automatic logic [24:0] clampLen(input logic [24:0] len, input logic [24:0] minLen);
        return (len < minLen) ? minLen : len;
    endfunction

endpackage

// File: rtl/motoro3_step_sequencer_if.sv
// motoro3_step_sequencer_if
// Groups the sequencer's control inputs and status outputs into one bundle.
//   start, stop, dirRev         : run/stop request pulses and step direction
//   m3r_stepLen, m3r_alignLen   : clocks per commutation step / alignment dwell
//   sgStep, m3cnt               : current step (15 = idle) and position in step
//   m3cntFirst1/2, m3cntLast1/2 : step-edge strobes
//   pwmActive1, busy            : PWM enable and not-idle status
// modport master drives the requests (controller side); slave is the sequencer.
interface motoro3_step_sequencer_if;

    logic        start;
    logic        stop;
    logic        dirRev;
    logic [24:0] m3r_stepLen;
    logic [24:0] m3r_alignLen;
    logic [3:0]  sgStep;
    logic [24:0] m3cnt;
    logic        m3cntFirst1;
    logic        m3cntFirst2;
    logic        m3cntLast1;
    logic        m3cntLast2;
    logic        pwmActive1;
    logic        busy;

    modport master (
        output start, stop, dirRev, m3r_stepLen, m3r_alignLen,
        input  sgStep, m3cnt, m3cntFirst1, m3cntFirst2, m3cntLast1, m3cntLast2,
               pwmActive1, busy
    );

    modport slave (
        input  start, stop, dirRev, m3r_stepLen, m3r_alignLen,
        output sgStep, m3cnt, m3cntFirst1, m3cntFirst2, m3cntLast1, m3cntLast2,
               pwmActive1, busy
    );

endinterface

// File: rtl/motoro3_step_counter.sv
// motoro3_step_counter
// 25-bit wrap counter with a latched length and First/Last position decode.
//   clk, rst  : clock and synchronous active-high reset
//   load      : restart at 0 and latch lenIn (has priority over enable)
//   enable    : count; on the last position wrap to 0 and re-latch lenIn
//   lenIn     : already-clamped length to latch
//   cnt       : current position
//   atLast    : cnt is the last position of the latched length
//   first1/first2/last2/last1 : raw position decodes (0, 1, L-2, L-1)
module motoro3_step_counter
    import motoro3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        enable,
    input  logic [24:0] lenIn,
    output logic [24:0] cnt,
    output logic        atLast,
    output logic        first1,
    output logic        first2,
    output logic        last2,
    output logic        last1
);

    logic [24:0] cntReg;
    logic [24:0] lenReg;

    // The length is only taken at load or wrap, so a mid-step change of the
    // requested length cannot stretch or cut the step in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            cntReg <= '0;
            lenReg <= STEP_LEN_MIN;
        end else if (load) begin
            cntReg <= '0;
            lenReg <= lenIn;
        end else if (enable) begin
            if (atLast) begin
                cntReg <= '0;
                lenReg <= lenIn;
            end else begin
                cntReg <= cntReg + 25'd1;
            end
        end
    end

    // Position decodes are purely combinational on the registered count.
    always_comb begin
        atLast = (cntReg == (lenReg - 25'd1));
        first1 = (cntReg == 25'd0);
        first2 = (cntReg == 25'd1);
        last2  = (cntReg == (lenReg - 25'd2));
        last1  = atLast;
        cnt    = cntReg;
    end

endmodule

// File: rtl/motoro3_step_sequencer.sv
// motoro3_step_sequencer
// Commutation step sequencer: on start it (optionally) dwells in an alignment
// phase on step 0, then walks sgStep through 0..11 (forward or reverse) with a
// configurable number of clocks per step, and finishes the current step
// cleanly on stop.
//   clk, rst : 10 MHz clock, synchronous active-high reset
//   bus      : motoro3_step_sequencer_if.slave (requests, lengths, step,
//              position, strobes, pwmActive1, busy)
// Optional feature macro: M3SEQ_ALIGN_EN enables the ALIGN phase and
// m3r_alignLen; without it start goes straight to RUN.
module motoro3_step_sequencer
    import motoro3_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    motoro3_step_sequencer_if.slave  bus
);

    seqState_t   state;
    seqState_t   stateNext;
    logic [3:0]  sgStepReg;
    logic [3:0]  sgStepNext;
    logic [3:0]  sgStepAdv;
    logic [24:0] stepLenEff;
    logic [24:0] lenSel;
    logic [24:0] cnt;
    logic        cntLoad;
    logic        cntEnable;
    logic        atLast;
    logic        cntFirst1;
    logic        cntFirst2;
    logic        cntLast2;
    logic        cntLast1;
    logic        stepPhase;

    // From IDLE the counter is preloaded with the alignment dwell when ALIGN
    // follows; every other load or wrap takes the step length.
`ifdef M3SEQ_ALIGN_EN
    logic [24:0] alignLenEff;
    always_comb begin
        stepLenEff  = clampLen(bus.m3r_stepLen, STEP_LEN_MIN);
        alignLenEff = clampLen(bus.m3r_alignLen, ALIGN_LEN_MIN);
        lenSel      = (state == ST_IDLE) ? alignLenEff : stepLenEff;
    end
`else
    logic [24:0] alignLenUnused;
    always_comb begin
        stepLenEff     = clampLen(bus.m3r_stepLen, STEP_LEN_MIN);
        lenSel         = stepLenEff;
        alignLenUnused = bus.m3r_alignLen;
    end
`endif

    motoro3_step_counter uStepCounter (
        .clk    (clk),
        .rst    (rst),
        .load   (cntLoad),
        .enable (cntEnable),
        .lenIn  (lenSel),
        .cnt    (cnt),
        .atLast (atLast),
        .first1 (cntFirst1),
        .first2 (cntFirst2),
        .last2  (cntLast2),
        .last1  (cntLast1)
    );

    // State and step registers; reset drops any partial step immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sgStepReg <= SG_STEP_IDLE;
        end else begin
            state     <= stateNext;
            sgStepReg <= sgStepNext;
        end
    end

    // Next state, counter control and step advance. Stop always beats start,
    // start is only honoured from IDLE, and a stop in RUN lets the current
    // step run out before returning to IDLE without a further advance.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
`ifdef M3SEQ_ALIGN_EN
                    stateNext = ST_ALIGN;
`else
                    stateNext = ST_RUN;
`endif
                end
            end
`ifdef M3SEQ_ALIGN_EN
            ST_ALIGN: begin
                if (bus.stop) begin
                    stateNext = ST_IDLE;
                end else if (atLast) begin
                    stateNext = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                if (bus.stop) begin
                    stateNext = atLast ? ST_IDLE : ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (atLast) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        cntEnable = (state != ST_IDLE);
        cntLoad   = (state == ST_IDLE) || (stateNext == ST_IDLE) ||
                    ((state == ST_ALIGN) && (stateNext == ST_RUN));

        if (bus.dirRev) begin
            sgStepAdv = (sgStepReg == 4'd0) ? SG_STEP_MAX : (sgStepReg - 4'd1);
        end else begin
            sgStepAdv = (sgStepReg == SG_STEP_MAX) ? 4'd0 : (sgStepReg + 4'd1);
        end

        sgStepNext = sgStepReg;
        if (stateNext == ST_IDLE) begin
            sgStepNext = SG_STEP_IDLE;
        end else if (state == ST_IDLE) begin
            sgStepNext = 4'd0;
        end else if ((state == ST_RUN) && atLast) begin
            sgStepNext = sgStepAdv;
        end
    end

    // Strobes are only meaningful while steps are being issued.
    always_comb begin
        stepPhase       = (state == ST_RUN) || (state == ST_STOPPING);
        bus.sgStep      = sgStepReg;
        bus.m3cnt       = cnt;
        bus.m3cntFirst1 = stepPhase && cntFirst1;
        bus.m3cntFirst2 = stepPhase && cntFirst2;
        bus.m3cntLast2  = stepPhase && cntLast2;
        bus.m3cntLast1  = stepPhase && cntLast1;
        bus.pwmActive1  = (state != ST_IDLE);
        bus.busy        = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// tb_motoro3_step_sequencer
// Self-checking bench for motoro3_step_sequencer. Expected output snapshots
// are queued when stimulus is applied and popped when the DUT is sampled on
// the falling clock edge. A vector table covers steady-state stepping; short
// hand-written sequences cover direction change, stop, reset, mid-step length
// change, start/stop collisions and the alignment phase (M3SEQ_ALIGN_EN).
module tb_motoro3_step_sequencer;

    typedef struct packed {
        logic [3:0]  sg;
        logic [24:0] cnt;
        logic [3:0]  strb;
        logic        pwm;
        logic        busy;
    } expOut_t;

    typedef struct {
        logic [24:0] stepLen;
        logic        dirRev;
        int          k;
        logic [3:0]  sg;
        int          cnt;
        logic [3:0]  strb;
    } vec_t;

    localparam logic [3:0] S_F1 = 4'b1000;
    localparam logic [3:0] S_F2 = 4'b0100;
    localparam logic [3:0] S_L2 = 4'b0010;
    localparam logic [3:0] S_L1 = 4'b0001;
    localparam logic [3:0] S_NO = 4'b0000;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   curK;
    expOut_t expQ[$];
    vec_t    vecs[$];

    motoro3_step_sequencer_if busIf();

    motoro3_step_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    // 10 MHz clock.
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Guard against the run never finishing.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic expOut_t sampleDut();
        expOut_t a;
        a.sg   = busIf.sgStep;
        a.cnt  = busIf.m3cnt;
        a.strb = {busIf.m3cntFirst1, busIf.m3cntFirst2, busIf.m3cntLast2, busIf.m3cntLast1};
        a.pwm  = busIf.pwmActive1;
        a.busy = busIf.busy;
        return a;
    endfunction

    function automatic void pushRun(input logic [3:0] sg, input int cnt, input logic [3:0] strb);
        expOut_t e;
        e.sg   = sg;
        e.cnt  = cnt[24:0];
        e.strb = strb;
        e.pwm  = 1'b1;
        e.busy = 1'b1;
        expQ.push_back(e);
    endfunction

    function automatic void pushIdle();
        expOut_t e;
        e.sg   = 4'd15;
        e.cnt  = '0;
        e.strb = S_NO;
        e.pwm  = 1'b0;
        e.busy = 1'b0;
        expQ.push_back(e);
    endfunction

    task automatic checkOutput(input string name);
        expOut_t e;
        expOut_t a;
        a = sampleDut();
        checks++;
        if (expQ.size() == 0) begin
            $display("[TB] FAIL %s: scoreboard empty, got sg=%0d cnt=%0d, required a queued expectation", name, a.sg, a.cnt);
        end else begin
            e = expQ.pop_front();
            if (a !== e) begin
                $display("[TB] FAIL %s: got sg=%0d cnt=%0d strb=%b pwm=%b busy=%b, required sg=%0d cnt=%0d strb=%b pwm=%b busy=%b",
                         name, a.sg, a.cnt, a.strb, a.pwm, a.busy, e.sg, e.cnt, e.strb, e.pwm, e.busy);
            end else begin
                passes++;
            end
        end
    endtask

    task automatic tickTo(input int k);
        while (curK < k) begin
            @(negedge clk);
            curK++;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst          = 1'b1;
        busIf.start  = 1'b0;
        busIf.stop   = 1'b0;
        busIf.dirRev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulses start from the current falling edge; returns at the sample point
    // of the first active cycle (k = 0).
    task automatic startRun(input logic [24:0] stepLen, input logic dirRev, input logic [24:0] alignLen);
        busIf.m3r_stepLen  = stepLen;
        busIf.m3r_alignLen = alignLen;
        busIf.dirRev       = dirRev;
        busIf.start        = 1'b1;
        @(negedge clk);
        busIf.start = 1'b0;
        curK = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        doReset();
        startRun(v.stepLen, v.dirRev, 25'd0);
        pushRun(v.sg, v.cnt, v.strb);
        tickTo(v.k);
        checkOutput($sformatf("vec L=%0d rev=%0d k=%0d", v.stepLen, v.dirRev, v.k));
    endtask

    initial begin
        checks             = 0;
        passes             = 0;
        curK               = 0;
        rst                = 1'b1;
        busIf.start        = 1'b0;
        busIf.stop         = 1'b0;
        busIf.dirRev       = 1'b0;
        busIf.m3r_stepLen  = 25'd10;
        busIf.m3r_alignLen = 25'd0;

        vecs.push_back('{25'd10, 1'b0,   0,  4'd0, 0, S_F1});
        vecs.push_back('{25'd10, 1'b0,   1,  4'd0, 1, S_F2});
        vecs.push_back('{25'd10, 1'b0,   8,  4'd0, 8, S_L2});
        vecs.push_back('{25'd10, 1'b0,   9,  4'd0, 9, S_L1});
        vecs.push_back('{25'd10, 1'b0,  10,  4'd1, 0, S_F1});
        vecs.push_back('{25'd10, 1'b0,  55,  4'd5, 5, S_NO});
        vecs.push_back('{25'd10, 1'b0, 119, 4'd11, 9, S_L1});
        vecs.push_back('{25'd10, 1'b0, 120,  4'd0, 0, S_F1});
        vecs.push_back('{25'd2,  1'b0,   0,  4'd0, 0, S_F1});
        vecs.push_back('{25'd2,  1'b0,   1,  4'd0, 1, S_F2});
        vecs.push_back('{25'd2,  1'b0,   2,  4'd0, 2, S_L2});
        vecs.push_back('{25'd2,  1'b0,   3,  4'd0, 3, S_L1});
        vecs.push_back('{25'd2,  1'b0,   4,  4'd1, 0, S_F1});
        vecs.push_back('{25'd0,  1'b0,   7,  4'd1, 3, S_L1});
        vecs.push_back('{25'd4,  1'b0,   6,  4'd1, 2, S_L2});
        vecs.push_back('{25'd5,  1'b0,  13,  4'd2, 3, S_L2});
        vecs.push_back('{25'd10, 1'b1,  10, 4'd11, 0, S_F1});
        vecs.push_back('{25'd10, 1'b1,  25, 4'd10, 5, S_NO});

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pushIdle();
        checkOutput("reset idle");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Direction change mid-step only takes effect at the next wrap.
        doReset();
        startRun(25'd10, 1'b0, 25'd0);
        tickTo(15);
        busIf.dirRev = 1'b1;
        tickTo(19);
        pushRun(4'd1, 9, S_L1);
        checkOutput("dir hold until wrap");
        tickTo(20);
        pushRun(4'd0, 0, S_F1);
        checkOutput("dir reversed at wrap");
        tickTo(30);
        pushRun(4'd11, 0, S_F1);
        checkOutput("dir reverse wrap 0->11");

        // Start while running is ignored; stop in step 4 finishes that step.
        doReset();
        startRun(25'd10, 1'b0, 25'd0);
        tickTo(20);
        busIf.start = 1'b1;
        tickTo(21);
        busIf.start = 1'b0;
        pushRun(4'd2, 1, S_F2);
        checkOutput("start while busy");
        tickTo(43);
        busIf.stop = 1'b1;
        tickTo(44);
        busIf.stop = 1'b0;
        pushRun(4'd4, 4, S_NO);
        checkOutput("stopping keeps step");
        tickTo(49);
        pushRun(4'd4, 9, S_L1);
        checkOutput("stopping last1");
        tickTo(50);
        pushIdle();
        checkOutput("stop to idle");
        tickTo(60);
        pushIdle();
        checkOutput("no step after stop");

        // Mid-step length change applies from the next step.
        doReset();
        startRun(25'd10, 1'b0, 25'd0);
        tickTo(3);
        busIf.m3r_stepLen = 25'd6;
        tickTo(9);
        pushRun(4'd0, 9, S_L1);
        checkOutput("old length kept");
        tickTo(14);
        pushRun(4'd1, 4, S_L2);
        checkOutput("new length last2");
        tickTo(16);
        pushRun(4'd2, 0, S_F1);
        checkOutput("new length wrap");

        // Reset mid-step overrides a simultaneous start; restart from step 0.
        doReset();
        startRun(25'd10, 1'b0, 25'd0);
        tickTo(76);
        pushRun(4'd7, 6, S_NO);
        checkOutput("before reset");
        rst         = 1'b1;
        busIf.start = 1'b1;
        tickTo(77);
        pushIdle();
        checkOutput("reset mid-step");
        rst         = 1'b0;
        busIf.start = 1'b0;
        startRun(25'd10, 1'b0, 25'd0);
        pushRun(4'd0, 0, S_F1);
        checkOutput("restart after reset");

        // Start and stop together from IDLE: stop wins.
        doReset();
        busIf.start = 1'b1;
        busIf.stop  = 1'b1;
        @(negedge clk);
        busIf.start = 1'b0;
        busIf.stop  = 1'b0;
        pushIdle();
        checkOutput("start+stop idle");

`ifdef M3SEQ_ALIGN_EN
        // Alignment dwell on step 0 with no strobes, then RUN.
        doReset();
        startRun(25'd8, 1'b0, 25'd20);
        pushRun(4'd0, 0, S_NO);
        checkOutput("align start");
        tickTo(19);
        pushRun(4'd0, 19, S_NO);
        checkOutput("align end");
        tickTo(20);
        pushRun(4'd0, 0, S_F1);
        checkOutput("run after align");
        tickTo(28);
        pushRun(4'd1, 0, S_F1);
        checkOutput("first step after align");
`else
        // Without the alignment phase the dwell length is ignored.
        doReset();
        startRun(25'd8, 1'b0, 25'd20);
        pushRun(4'd0, 0, S_F1);
        checkOutput("no align direct run");
        tickTo(8);
        pushRun(4'd1, 0, S_F1);
        checkOutput("no align first wrap");
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/motoro3_step_sequencer.md
MOTORO3_STEP_SEQUENCER -- requirements
Module: motoro3_step_sequencer

Interface
REQ-001 SHALL have ports: clk input 1 (10 MHz, single clock domain, all logic on rising edge); rst input 1 (synchronous, active-high).
REQ-002 SHALL have ports: start input 1 (run request pulse); stop input 1 (stop request pulse); dirRev input 1 (0 = step+1, 1 = step-1).
REQ-003 SHALL have ports: m3r_stepLen input 25 (clocks per commutation step); m3r_alignLen input 25 (alignment dwell, clocks).
REQ-004 SHALL have ports: sgStep output 4 (0..11 active, 15 idle); m3cnt output 25 (position within step).
REQ-005 SHALL have ports: m3cntFirst1, m3cntFirst2, m3cntLast1, m3cntLast2, each output 1 (step-edge strobes).
REQ-006 SHALL have ports: pwmActive1 output 1 (PWM generator enable); busy output 1 (not IDLE).

Function
REQ-007 SHALL implement FSM states IDLE, ALIGN, RUN, STOPPING.
REQ-008 IDLE: sgStep=15, m3cnt=0, all strobes 0, pwmActive1=0, busy=0; start -> ALIGN (or RUN per REQ-020).
REQ-009 Effective step length L = max(m3r_stepLen, 4), sampled into an internal register on entry to ALIGN/RUN and at every step wrap; mid-step changes SHALL have no effect until the next wrap.
REQ-010 In RUN, m3cnt SHALL count 0..L-1 and then wrap to 0, and sgStep SHALL advance on that wrap edge.
REQ-011 Strobes SHALL be combinational on registered m3cnt, valid only in RUN/STOPPING: First1 at m3cnt==0, First2 at m3cnt==1, Last2 at m3cnt==L-2, Last1 at m3cnt==L-1; exactly one pulse of each per step.
REQ-012 Step advance: dirRev=0 -> 11 wraps to 0; dirRev=1 -> 0 wraps to 11; dirRev SHALL be sampled at the wrap only.
REQ-013 RUN entry SHALL start with sgStep=0 and m3cnt=0, so First1 is asserted in the first RUN cycle.
REQ-014 pwmActive1 SHALL be 1 in ALIGN, RUN and STOPPING, and 0 otherwise.
REQ-015 stop in RUN -> STOPPING; the current step SHALL complete and then, at the Last1 cycle, transition to IDLE with no further step advance.
REQ-016 stop in ALIGN SHALL go to IDLE on the next clock.
REQ-017 start while busy SHALL be ignored; start and stop in the same cycle SHALL resolve as stop wins (IDLE stays IDLE).
REQ-018 ALIGN: sgStep=0, m3cnt counts 0..max(m3r_alignLen,1)-1, strobes 0; at the end -> RUN with m3cnt=0.

Reset
REQ-019 rst SHALL force IDLE and all outputs to IDLE values (sgStep=15, m3cnt=0, strobes 0, pwmActive1=0, busy=0) on the next clock, overriding start/stop and any mid-step state; no partial step SHALL be completed.

Configuration
REQ-020 Macro M3SEQ_ALIGN_EN: when defined, the ALIGN state and m3r_alignLen are functional; when undefined, start goes IDLE -> RUN directly, m3r_alignLen is ignored, and the ALIGN state is not synthesized.

Structure
REQ-021 Shared package motoro3_pkg SHALL hold the FSM state encoding, SG_STEP_IDLE=4'd15, SG_STEP_MAX=4'd11 and STEP_LEN_MIN=25'd4.
REQ-022 One sub-module motoro3_step_counter (25-bit wrap counter with length latch and First/Last decode) SHALL be instantiated; the FSM and step advance logic SHALL stay in the top level.

Verification
REQ-023 Scenario: ALIGN_EN undefined, stepLen=10, dirRev=0, start -> sgStep 0,1,...,11,0 every 10 clocks; First1 at m3cnt 0, First2 at 1, Last2 at 8, Last1 at 9.
REQ-024 Scenario: stepLen=2 -> effective L=4; First1/First2/Last2/Last1 occupy 4 distinct consecutive cycles per step.
REQ-025 Scenario: dirRev=1 from start -> sgStep 0,11,10,...; dirRev toggled at m3cnt=5 of L=10 -> direction changes only at the next wrap.
REQ-026 Scenario: stop at m3cnt=3 of L=10 in step 4 -> step 4 completes, then IDLE after Last1 (sgStep=15, pwmActive1=0); step 5 is never issued.
REQ-027 Scenario: ALIGN_EN defined, alignLen=20, stepLen=8 -> pwmActive1=1 and sgStep=0 with no strobes for 20 clocks, then First1 and RUN begin.
REQ-028 Scenario: rst pulsed at m3cnt=6 of step 7 -> all outputs take IDLE values the next cycle; a subsequent start restarts from sgStep=0.
